// File: rtl/seven_seg_scan_controller.sv
// Time-multiplexed driver for a 4-digit seven-segment display.
// Scans digits 0..3, giving each digit DIV cycles. The first DEAD cycles of
// each slot keep every anode off to prevent ghosting. The display inputs are
// captured once per frame, so a frame never shows a mix of old and new values.
//
// Ports:
//   Clk           system clock, rising edge
//   Reset         synchronous active-high reset
//   Value         four hex nibbles, nibble i belongs to digit i (digit 0 rightmost)
//   DigitEn       per-digit enable, 1 = digit may light
//   Dp            per-digit decimal point request, 1 = on
//   LeadZeroBlank 1 = suppress leading zero digits
//   HexVal        nibble of the current digit, to the segment decoder
//   An            active-low anode enables, An[i] drives digit i
//   DpOut         active-low decimal point segment
//   Digit         index of the current slot
//   FrameTick     one-cycle pulse in the cycle the frame snapshot is taken
module seven_seg_scan_controller #(
   parameter int unsigned DIV  = 100000,
   parameter int unsigned DEAD = 1000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [15:0] Value,
   input  logic [3:0]  DigitEn,
   input  logic [3:0]  Dp,
   input  logic        LeadZeroBlank,
   output logic [3:0]  HexVal,
   output logic [3:0]  An,
   output logic        DpOut,
   output logic [1:0]  Digit,
   output logic        FrameTick
);

   localparam int unsigned CW = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD);

   logic [CW-1:0] cnt;
   logic [1:0]    d;
   logic [15:0]   fv;
   logic [3:0]    fen;
   logic [3:0]    fdp;
   logic          flzb;

   logic          slot_last;
   logic          frame_last;
   logic [3:0]    blank;
   logic          lit;

   // End of slot / end of frame decode
   always_comb begin
      slot_last  = (cnt == CNT_LAST);
      frame_last = slot_last && (d == 2'd3);
   end

   // Slot counter, digit index and once-per-frame input snapshot
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt  <= '0;
         d    <= 2'd0;
         fv   <= 16'h0000;
         fen  <= 4'h0;
         fdp  <= 4'h0;
         flzb <= 1'b0;
      end else begin
         if (slot_last) begin
            cnt <= '0;
            d   <= d + 2'd1;
         end else begin
            cnt <= cnt + CW'(1);
         end
         if (frame_last) begin
            fv   <= Value;
            fen  <= DigitEn;
            fdp  <= Dp;
            flzb <= LeadZeroBlank;
         end
      end
   end

   // Digit i is a leading zero when it and every digit to its left are zero;
   // digit 0 always shows so a zero value still reads "0"
   always_comb begin
      blank[0] = 1'b0;
      blank[1] = flzb && (fv[15:4]  == 12'h000);
      blank[2] = flzb && (fv[15:8]  == 8'h00);
      blank[3] = flzb && (fv[15:12] == 4'h0);
   end

   // Output decode, driven from registered state only
   always_comb begin
      lit = (cnt >= DEAD_CNT) && fen[d] && !blank[d];
      case (d)
         2'd0:    HexVal = fv[3:0];
         2'd1:    HexVal = fv[7:4];
         2'd2:    HexVal = fv[11:8];
         default: HexVal = fv[15:12];
      endcase
      An        = lit ? ~(4'b0001 << d) : 4'b1111;
      DpOut     = lit ? ~fdp[d] : 1'b1;
      Digit     = d;
      FrameTick = frame_last;
   end

endmodule
